// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and defaults for the port-B BRAM arbiter
package bram_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 8;
    localparam int DEF_RD_LAT = 2;

    localparam int REQ_KEY  = 0;
    localparam int REQ_AES  = 1;
    localparam int REQ_HASH = 2;

endpackage

// File: rtl/bram_portb_arbiter_rr_arbiter.sv
// rtl/bram_portb_arbiter_rr_arbiter.sv - round-robin pick with rotating priority pointer
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic             valid,
    output logic [IW-1:0]    pick
);

    logic [IW-1:0] ptr;

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        valid = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && valid) begin
            ptr <= (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
        end
    end

endmodule

// File: rtl/bram_portb_arbiter.sv
// rtl/bram_portb_arbiter.sv - port-B BRAM arbiter: round-robin grant, burst lock, read-return steering
// Optional address range checking: BRAM_ADDR_RANGE_CHECK_EN
module bram_portb_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N_REQ           = 3,
    parameter int AW              = DEF_AW,
    parameter int DW              = DEF_DW,
    parameter int RD_LAT          = DEF_RD_LAT,
    parameter logic [AW-1:0] ADDR_MAX = AW'(32'h0000_0FFF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic [N_REQ-1:0]    err,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_din,
    input  logic [DW-1:0]       mem_dout,
    output logic                mem_we,
    output logic                busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef BRAM_ADDR_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    arb_state_t        state;
    logic [IW-1:0]     owner;
    logic              lock_hold;
    logic              rr_valid;
    logic [IW-1:0]     rr_pick;
    logic              gnt_any;
    logic [IW-1:0]     gnt_id;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic              sel_we;
    logic              sel_lock;
    logic              oob;
    logic              issue;
    logic [RD_LAT-1:0] pipe_v;
    logic [IW-1:0]     pipe_id [RD_LAT];

    // The lock owner keeps the port only while both its req and lock stay high.
    assign lock_hold = (state == ARB_LOCKED) && req[owner] && lock[owner];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (!lock_hold),
        .valid   (rr_valid),
        .pick    (rr_pick)
    );

    assign gnt_any   = rst_n && (lock_hold || rr_valid);
    assign gnt_id    = lock_hold ? owner : rr_pick;
    assign gnt       = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
    assign sel_addr  = addr[gnt_id*AW +: AW];
    assign sel_wdata = wdata[gnt_id*DW +: DW];
    assign sel_we    = we[gnt_id];
    assign sel_lock  = lock[gnt_id];

    // Out-of-range requests are still consumed so the requester does not stall.
    assign oob   = RANGE_EN && (sel_addr > ADDR_MAX);
    assign err   = (gnt_any && oob) ? gnt : '0;
    assign issue = gnt_any && !oob;

    assign busy = (state == ARB_LOCKED) || (|pipe_v) || (|rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            pipe_v   <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_id[k] <= '0;
            end
        end else begin
            mem_we <= issue && sel_we;
            if (issue) begin
                mem_addr <= sel_addr;
                mem_din  <= sel_wdata;
            end

            pipe_v[0]  <= issue && !sel_we;
            pipe_id[0] <= gnt_id;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_id[k] <= pipe_id[k-1];
            end

            // Last stage lines up with mem_dout for the read issued RD_LAT cycles ago.
            rvalid <= pipe_v[RD_LAT-1] ? (N_REQ'(1) << pipe_id[RD_LAT-1]) : '0;
            if (pipe_v[RD_LAT-1]) begin
                rdata <= mem_dout;
            end

            if (!lock_hold) begin
                if (gnt_any && sel_lock) begin
                    state <= ARB_LOCKED;
                    owner <= gnt_id;
                end else begin
                    state <= ARB_IDLE;
                end
            end
        end
    end

endmodule
